// File: rtl/nios_system_onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM (round-robin or fixed priority).
// Optional macro NIOS_SYSTEM_ONCHIP_MEMORY_ARBITER_RANGE_CHECK_EN: out-of-range accesses are absorbed and flagged on range_err.
module nios_system_onchip_memory_arbiter #(
   parameter int ADDR_W        = 14,
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 12288,
   parameter bit RR_EN_DEFAULT = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
`ifdef NIOS_SYSTEM_ONCHIP_MEMORY_ARBITER_RANGE_CHECK_EN
   output logic                range_err,
`endif
   input  logic                rr_enable
);

   logic                w_m0_req, w_m1_req, w_any, w_gnt0, w_gnt1;
   logic                w_wr, w_oor, w_issue;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_rdata;
   logic [1:0]          r_rd_pend;
   logic                r_last_grant;   // 1 = m1 was granted last
   logic                r_rr_en;
   logic [ADDR_W-1:0]   r_addr;

   assign w_m0_req = m0_read | m0_write;
   assign w_m1_req = m1_read | m1_write;
   assign w_any    = w_m0_req | w_m1_req;

   // m1 wins alone, or under round-robin when m0 held the last grant
   assign w_gnt1 = w_m1_req & (~w_m0_req | (r_rr_en & ~r_last_grant));
   assign w_gnt0 = w_m0_req & ~w_gnt1;

   assign w_addr = w_gnt1 ? m1_address : m0_address;
   assign w_wr   = w_gnt1 ? m1_write   : m0_write;

`ifdef NIOS_SYSTEM_ONCHIP_MEMORY_ARBITER_RANGE_CHECK_EN
   logic r_oor_rd, r_range_err;
   assign w_oor     = w_any & (int'(w_addr) >= DEPTH);
   assign w_rdata   = r_oor_rd ? DATA_W'(32'hDEADBEEF) : mem_readdata;
   assign range_err = r_range_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_oor_rd    <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         r_oor_rd    <= w_oor & ~w_wr;
         r_range_err <= r_range_err | w_oor;
      end
   end
`else
   logic w_unused;
   assign w_oor    = 1'b0;
   assign w_rdata  = mem_readdata;
   assign w_unused = DEPTH[0];
`endif

   assign w_issue        = w_any & ~w_oor;
   assign mem_chipselect = w_issue;
   assign mem_write      = w_issue & w_wr;
   assign mem_address    = w_issue ? w_addr : r_addr;
   assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
   assign mem_clken      = ~reset;

   assign m0_waitrequest   = w_m0_req & ~w_gnt0;
   assign m1_waitrequest   = w_m1_req & ~w_gnt1;
   assign m0_readdatavalid = r_rd_pend[0];
   assign m1_readdatavalid = r_rd_pend[1];
   assign m0_readdata      = w_rdata;
   assign m1_readdata      = w_rdata;

   // rr_enable is a static strap; its registered copy starts at RR_EN_DEFAULT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_pend    <= 2'b00;
         r_last_grant <= 1'b1;
         r_rr_en      <= RR_EN_DEFAULT;
         r_addr       <= '0;
      end else begin
         r_rd_pend <= {w_gnt1 & m1_read & ~m1_write, w_gnt0 & m0_read & ~m0_write};
         r_rr_en   <= rr_enable;
         if (w_any)   r_last_grant <= w_gnt1;
         if (w_issue) r_addr       <= w_addr;
      end
   end

endmodule
